// File: rtl/snake_pkg.sv
// Shared constants, colour type and probe FSM encoding for the cell probe reader.
package snake_pkg;

    localparam int XSCREEN = 160;
    localparam int YSCREEN = 120;
    localparam int XDIM    = 10;
    localparam int YDIM    = 10;

    typedef logic [2:0] colour_t;

    localparam colour_t BG = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } probe_state_t;

    // True when a full-width pixel address falls outside the visible screen.
    function automatic logic pixel_off_screen(input logic [8:0] px, input logic [7:0] py,
                                              input int xs, input int ys);
        return (int'(px) >= xs) || (int'(py) >= ys);
    endfunction

endpackage

// File: rtl/cell_probe_reader_if.sv
// Probe request, framebuffer read port and result bus of the cell probe reader.
interface cell_probe_reader_if;

    logic                  start;
    logic [7:0]            cell_x;
    logic [6:0]            cell_y;
    logic                  rd_en;
    logic [7:0]            rd_x;
    logic [6:0]            rd_y;
    snake_pkg::colour_t    rd_colour;
    logic                  busy;
    logic                  done;
    logic                  hit;
    snake_pkg::colour_t    hit_colour;
    logic [6:0]            hit_count;
    logic                  off_screen;

    modport slave (
        input  start, cell_x, cell_y, rd_colour,
        output rd_en, rd_x, rd_y, busy, done, hit, hit_colour, hit_count, off_screen
    );

    modport master (
        output start, cell_x, cell_y, rd_colour,
        input  rd_en, rd_x, rd_y, busy, done, hit, hit_colour, hit_count, off_screen
    );

endinterface

// File: rtl/cell_scan_counter.sv
// Nested x/y offset counters walking a cell in raster order (x fastest).
module cell_scan_counter #(
    parameter int XDIM = 10,
    parameter int YDIM = 10,
    parameter int XW   = (XDIM > 1) ? $clog2(XDIM) : 1,
    parameter int YW   = (YDIM > 1) ? $clog2(YDIM) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [XW-1:0] x_off,
    output logic [YW-1:0] y_off,
    output logic          last
);

    logic [XW-1:0] r_x_off;
    logic [YW-1:0] r_y_off;

    // Advance the x offset every enabled cycle, carrying into y at the row end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x_off <= '0;
            r_y_off <= '0;
        end else if (clear) begin
            r_x_off <= '0;
            r_y_off <= '0;
        end else if (enable) begin
            if (r_x_off == XW'(XDIM - 1)) begin
                r_x_off <= '0;
                if (r_y_off == YW'(YDIM - 1)) begin
                    r_y_off <= '0;
                end else begin
                    r_y_off <= r_y_off + YW'(1);
                end
            end else begin
                r_x_off <= r_x_off + XW'(1);
            end
        end else begin
            r_x_off <= r_x_off;
            r_y_off <= r_y_off;
        end
    end

    assign x_off = r_x_off;
    assign y_off = r_y_off;
    assign last  = (r_x_off == XW'(XDIM - 1)) && (r_y_off == YW'(YDIM - 1));

endmodule

// File: rtl/cell_probe_reader.sv
// Scans one XDIM x YDIM cell of the framebuffer and reports whether any
// on-screen pixel differs from the background, plus the first such colour
// and how many there are.
module cell_probe_reader
    import snake_pkg::*;
#(
    parameter int      XDIM    = snake_pkg::XDIM,
    parameter int      YDIM    = snake_pkg::YDIM,
    parameter int      XSCREEN = snake_pkg::XSCREEN,
    parameter int      YSCREEN = snake_pkg::YSCREEN,
    parameter colour_t BG      = snake_pkg::BG
) (
    input  logic                clk,
    input  logic                reset,
    cell_probe_reader_if.slave  bus
);

    localparam int XW   = (XDIM > 1) ? $clog2(XDIM) : 1;
    localparam int YW   = (YDIM > 1) ? $clog2(YDIM) : 1;
    localparam int NPIX = XDIM * YDIM;

    probe_state_t  r_state;
    logic [7:0]    r_cell_x;
    logic [6:0]    r_cell_y;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;
    logic          r_hit;
    colour_t       r_hit_colour;
    logic [6:0]    r_hit_count;
    logic          r_off_screen;

    logic [XW-1:0] w_x_off;
    logic [YW-1:0] w_y_off;
    logic          w_last;
    logic [8:0]    w_px;
    logic [7:0]    w_py;
    logic          w_off;
    logic          w_issue;
    logic          w_capture;

    cell_scan_counter #(
        .XDIM (XDIM),
        .YDIM (YDIM),
        .XW   (XW),
        .YW   (YW)
    ) u_scan (
        .clk    (clk),
        .reset  (reset),
        .clear  (r_state == ST_IDLE),
        .enable (r_state == ST_READ),
        .x_off  (w_x_off),
        .y_off  (w_y_off),
        .last   (w_last)
    );

    // Full-width pixel address and its read qualification; no wrap-around so
    // a cell hanging off the right/bottom edge is detected, not aliased.
    always_comb begin
        w_px      = {1'b0, r_cell_x} + 9'(w_x_off);
        w_py      = {1'b0, r_cell_y} + 8'(w_y_off);
        w_off     = pixel_off_screen(w_px, w_py, XSCREEN, YSCREEN);
        w_issue   = (r_state == ST_READ) && !w_off;
        w_capture = r_valid && (bus.rd_colour != BG);
    end

    // Returned data belongs to the read issued one cycle earlier; reset drops it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_issue;
        end
    end

    // Probe FSM with result accumulation; results hold until the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cell_x     <= 8'd0;
            r_cell_y     <= 7'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_hit        <= 1'b0;
            r_hit_colour <= 3'b000;
            r_hit_count  <= 7'd0;
            r_off_screen <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state      <= ST_READ;
                        r_busy       <= 1'b1;
                        r_cell_x     <= bus.cell_x;
                        r_cell_y     <= bus.cell_y;
                        r_hit        <= 1'b0;
                        r_hit_colour <= 3'b000;
                        r_hit_count  <= 7'd0;
                        r_off_screen <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (w_off) begin
                        r_off_screen <= 1'b1;
                    end
                    if (w_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_capture && r_busy) begin
                r_hit <= 1'b1;
                if (!r_hit) begin
                    r_hit_colour <= bus.rd_colour;
                end
                if (r_hit_count != 7'(NPIX)) begin
                    r_hit_count <= r_hit_count + 7'd1;
                end
            end
        end
    end

    assign bus.rd_en      = w_issue;
    assign bus.rd_x       = w_issue ? w_px[7:0] : 8'd0;
    assign bus.rd_y       = w_issue ? w_py[6:0] : 7'd0;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.hit        = r_hit;
    assign bus.hit_colour = r_hit_colour;
    assign bus.hit_count  = r_hit_count;
    assign bus.off_screen = r_off_screen;

endmodule

// File: tb/tb_cell_probe_reader.sv
// Bench for cell_probe_reader: framebuffer model plus a raster-order reference
// of reads, hits and off-screen pixels computed from the cell coordinates.
module tb_cell_probe_reader;

    localparam int XD = 10;
    localparam int YD = 10;
    localparam int XS = 160;
    localparam int YS = 120;
    localparam logic [2:0] BGC = 3'b000;

    typedef struct {
        int k;
        int x;
        int y;
    } rd_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    logic [2:0] fb [0:XS-1][0:YS-1];
    rd_t        rd_q[$];
    int         n_done;
    int         done_k;
    int         busy_n;

    cell_probe_reader_if bus ();

    cell_probe_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer: data one cycle after a read, junk when nothing was read.
    always @(posedge clk) begin
        if (bus.rd_en && (int'(bus.rd_x) < XS) && (int'(bus.rd_y) < YS))
            bus.rd_colour <= fb[bus.rd_x][bus.rd_y];
        else
            bus.rd_colour <= 3'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fb_fill(input int density);
        for (int x = 0; x < XS; x++)
            for (int y = 0; y < YS; y++)
                fb[x][y] = ($urandom_range(0, 99) < density) ? 3'($urandom_range(1, 7)) : BGC;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_rd_en"},  32'(bus.rd_en), 32'd0);
        chk({tag, "_rd_x"},   32'(bus.rd_x), 32'd0);
        chk({tag, "_rd_y"},   32'(bus.rd_y), 32'd0);
        chk({tag, "_busy"},   32'(bus.busy), 32'd0);
        chk({tag, "_done"},   32'(bus.done), 32'd0);
        chk({tag, "_hit"},    32'(bus.hit), 32'd0);
        chk({tag, "_hcol"},   32'(bus.hit_colour), 32'd0);
        chk({tag, "_hcnt"},   32'(bus.hit_count), 32'd0);
        chk({tag, "_off"},    32'(bus.off_screen), 32'd0);
    endtask

    // Start a probe and watch 110 cycles; k counts cycles after the start edge.
    task automatic scan(input int cx, input int cy, input int repulse_k);
        rd_q.delete();
        n_done = 0;
        done_k = -1;
        busy_n = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.cell_x = 8'(cx);
        bus.cell_y = 7'(cy);
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.cell_x = 8'($urandom);
                bus.cell_y = 7'($urandom);
            end
            if (bus.rd_en) rd_q.push_back('{k: k, x: int'(bus.rd_x), y: int'(bus.rd_y)});
            if (bus.done) begin
                n_done++;
                done_k = k;
            end
            if (bus.busy) busy_n++;
            bus.start = (k == repulse_k) ? 1'b1 : 1'b0;
        end
    endtask

    // Reference: walk the cell in raster order straight from its coordinates.
    task automatic check_scan(input string tag, input int cx, input int cy);
        int nexp = 0;
        int nmatch = 0;
        int cnt = 0;
        logic h = 1'b0;
        logic [2:0] hc = 3'b000;
        logic off = 1'b0;
        for (int j = 0; j < YD; j++) begin
            for (int i = 0; i < XD; i++) begin
                int x = cx + i;
                int y = cy + j;
                if (x >= XS || y >= YS) begin
                    off = 1'b1;
                end else begin
                    if (nexp < rd_q.size())
                        if (rd_q[nexp].k == j * XD + i + 1 && rd_q[nexp].x == x && rd_q[nexp].y == y)
                            nmatch++;
                    nexp++;
                    if (fb[x][y] != BGC) begin
                        if (!h) hc = fb[x][y];
                        h = 1'b1;
                        cnt++;
                    end
                end
            end
        end
        if (cnt > XD * YD) cnt = XD * YD;
        chk({tag, "_nreads"},  rd_q.size(), nexp);
        chk({tag, "_addrs"},   nmatch, nexp);
        chk({tag, "_ndone"},   n_done, 1);
        chk({tag, "_done_at"}, done_k, XD * YD + 2);
        chk({tag, "_busy_n"},  busy_n, XD * YD + 1);
        chk({tag, "_hit"},     32'(bus.hit), 32'(h));
        chk({tag, "_hcol"},    32'(bus.hit_colour), 32'(hc));
        chk({tag, "_hcnt"},    32'(bus.hit_count), cnt);
        chk({tag, "_off"},     32'(bus.off_screen), 32'(off));
    endtask

    // Directed cases first, then randomized cells over randomized framebuffers.
    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.cell_x    = 8'd0;
        bus.cell_y    = 7'd0;
        bus.rd_colour = 3'b000;
        fb_fill(0);
        repeat (3) @(negedge clk);
        chk_idle_zero("por");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_zero("idle");

        scan(30, 30, 0);
        check_scan("all_bg", 30, 30);

        fb[35][32] = 3'b100;
        scan(30, 30, 0);
        check_scan("one_hit", 30, 30);
        chk("one_hit_col", 32'(bus.hit_colour), 32'h4);

        fb_fill(0);
        fb[159][119] = 3'b110;
        scan(155, 115, 0);
        check_scan("corner", 155, 115);
        chk("corner_nreads", rd_q.size(), 25);

        fb_fill(0);
        fb[31][30] = 3'b010;
        fb[30][31] = 3'b001;
        scan(30, 30, 0);
        check_scan("two_hit", 30, 30);
        chk("two_hit_col", 32'(bus.hit_colour), 32'h2);

        scan(30, 30, 40);
        check_scan("restart", 30, 30);

        // Reset in the middle of a scan that already has a hit.
        fb[31][30] = 3'b101;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.cell_x = 8'd30;
        bus.cell_y = 7'd30;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        chk("pre_rst_hit",  32'(bus.hit), 32'd1);
        reset = 1'b1;
        #1;
        chk_idle_zero("rst_mid");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_zero("rst_after");
        scan(30, 30, 0);
        check_scan("rst_rescan", 30, 30);

        // Every pixel non-background: count reaches its ceiling.
        for (int x = 40; x < 50; x++)
            for (int y = 60; y < 70; y++)
                fb[x][y] = 3'b111;
        scan(40, 60, 0);
        check_scan("full", 40, 60);

        for (int r = 0; r < 6; r++) begin
            fb_fill($urandom_range(0, 30));
            begin
                int cx = $urandom_range(0, 255);
                int cy = $urandom_range(0, 127);
                if (r < 3) begin
                    cx = $urandom_range(0, XS - XD);
                    cy = $urandom_range(0, YS - YD);
                end
                scan(cx, cy, (r == 5) ? $urandom_range(2, 100) : 0);
                check_scan($sformatf("rnd%0d", r), cx, cy);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
